// File: rtl/jtbubl_sndcomm.sv
// Main/sound Z80 mailbox: command and reply latches, sound NMI pulse generator and
// stretched sound-CPU reset. Define JTBUBL_SNDCOMM_STATUS_EN for the status register and overrun flag.
module jtbubl_sndcomm #(
   parameter int NMI_LEN = 4,
   parameter int RST_LEN = 16
) (
   input  logic       clk24,
   input  logic       rst,
   input  logic       cen3,
   input  logic       main_cs,
   input  logic       main_wrn,
   input  logic       main_rdn,
   input  logic [1:0] main_addr,
   input  logic [7:0] main_dout,
   output logic [7:0] main_din,
   input  logic       snd_cs,
   input  logic       snd_wrn,
   input  logic       snd_rdn,
   input  logic [1:0] snd_addr,
   input  logic [7:0] snd_dout,
   output logic [7:0] snd_din,
   output logic       snd_nmi_n,
   output logic       snd_rst
);
   typedef enum logic [1:0] { NMI_IDLE, NMI_PULSE, NMI_WAIT } nmi_state_t;

   localparam logic [7:0] NMI_LOAD = 8'(NMI_LEN - 1);
   localparam logic [7:0] RST_LOAD = 8'(RST_LEN);

   logic       main_wr_lvl, main_rd_lvl, snd_wr_lvl, snd_rd_lvl;
   logic       main_wr_q, main_rd_q, snd_wr_q, snd_rd_q;
   logic       main_wr_edge, main_rd_edge, snd_wr_edge, snd_rd_edge;
   logic       main_we0, main_re0, main_we3;
   logic       snd_re0, snd_we0, snd_we1, snd_we2;
   logic [7:0] cmd_latch, rep_latch, stretch, nmi_cnt;
   logic       cmd_pend, rep_pend, nmi_en, rst_req;
   nmi_state_t nmi_st;

   assign main_wr_lvl  = main_cs & ~main_wrn;
   assign main_rd_lvl  = main_cs & ~main_rdn;
   assign snd_wr_lvl   = snd_cs  & ~snd_wrn;
   assign snd_rd_lvl   = snd_cs  & ~snd_rdn;
   assign main_wr_edge = main_wr_lvl & ~main_wr_q;
   assign main_rd_edge = main_rd_lvl & ~main_rd_q;
   assign snd_wr_edge  = snd_wr_lvl  & ~snd_wr_q;
   assign snd_rd_edge  = snd_rd_lvl  & ~snd_rd_q;

   assign main_we0 = main_wr_edge & (main_addr == 2'd0);
   assign main_re0 = main_rd_edge & (main_addr == 2'd0);
   assign main_we3 = main_wr_edge & (main_addr == 2'd3);
   // A sound CPU held in reset cannot change mailbox state.
   assign snd_re0  = snd_rd_edge & (snd_addr == 2'd0) & ~snd_rst;
   assign snd_we0  = snd_wr_edge & (snd_addr == 2'd0) & ~snd_rst;
   assign snd_we1  = snd_wr_edge & (snd_addr == 2'd1) & ~snd_rst;
   assign snd_we2  = snd_wr_edge & (snd_addr == 2'd2) & ~snd_rst;

   assign snd_rst = rst_req | (stretch != 8'd0);

   // NOTE: rst is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
   always_ff @(posedge clk24) begin
      if (rst) begin
         main_wr_q <= 1'b0;
         main_rd_q <= 1'b0;
         snd_wr_q  <= 1'b0;
         snd_rd_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         main_wr_q <= main_wr_lvl;
         main_rd_q <= main_rd_lvl;
         snd_wr_q  <= snd_wr_lvl;
         snd_rd_q  <= snd_rd_lvl;
      end
   end

   // A main write racing a sound read wins: the new command stays pending.
   always_ff @(posedge clk24) begin
      if (rst) begin
         cmd_latch <= 8'h00;
         cmd_pend  <= 1'b0;
      end else if (main_we0) begin
         cmd_latch <= main_dout;
         cmd_pend  <= 1'b1;
      end else if (snd_re0) begin
         cmd_pend  <= 1'b0;
      end
   end

`ifdef JTBUBL_SNDCOMM_STATUS_EN
   logic       overrun;
   logic [7:0] status;

   always_ff @(posedge clk24) begin
      if (rst || snd_re0)             overrun <= 1'b0;
      else if (main_we0 && cmd_pend)  overrun <= 1'b1;
   end

   assign status = {5'b0, overrun, rep_pend, cmd_pend};
`endif

   always_ff @(posedge clk24) begin
      if (rst || snd_rst) begin
         rep_latch <= 8'h00;
         rep_pend  <= 1'b0;
      end else if (snd_we0) begin
         rep_latch <= snd_dout;
         rep_pend  <= 1'b1;
      end else if (main_re0) begin
         rep_pend  <= 1'b0;
      end
   end

   always_ff @(posedge clk24) begin
      if (rst || snd_rst) nmi_en <= 1'b0;
      else if (snd_we1)   nmi_en <= 1'b1;
      else if (snd_we2)   nmi_en <= 1'b0;
   end

   // A fresh reset request reloads the stretch even if one is already running.
   always_ff @(posedge clk24) begin
      if (rst) begin
         rst_req <= 1'b0;
         stretch <= RST_LOAD;
      end else begin
         if (main_we3) rst_req <= main_dout[0];
         if (main_we3 && main_dout[0])    stretch <= RST_LOAD;
         else if (cen3 && stretch != 8'd0) stretch <= stretch - 8'd1;
      end
   end

   always_ff @(posedge clk24) begin
      if (rst || snd_rst) begin
         nmi_st    <= NMI_IDLE;
         nmi_cnt   <= 8'd0;
         snd_nmi_n <= 1'b1;
      end else if (cen3) begin
         case (nmi_st)
            NMI_IDLE:
               if (cmd_pend && nmi_en) begin
                  nmi_st    <= NMI_PULSE;
                  nmi_cnt   <= NMI_LOAD;
                  snd_nmi_n <= 1'b0;
               end
            // Runs to completion regardless of nmi_en.
            NMI_PULSE:
               if (nmi_cnt == 8'd0) begin
                  nmi_st    <= NMI_WAIT;
                  snd_nmi_n <= 1'b1;
               end else begin
                  nmi_cnt <= nmi_cnt - 8'd1;
               end
            NMI_WAIT:
               if (!cmd_pend) nmi_st <= NMI_IDLE;
            default:
               nmi_st <= NMI_IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      main_din = 8'hff;
      if (main_rd_lvl) begin
         case (main_addr)
            2'd0:    main_din = rep_latch;
`ifdef JTBUBL_SNDCOMM_STATUS_EN
            2'd1:    main_din = status;
`endif
            default: main_din = 8'hff;
         endcase
      end
   end

   always_comb begin
      snd_din = 8'hff;
      if (snd_rd_lvl) begin
         case (snd_addr)
            2'd0:    snd_din = cmd_latch;
`ifdef JTBUBL_SNDCOMM_STATUS_EN
            2'd1:    snd_din = status;
`endif
            default: snd_din = 8'hff;
         endcase
      end
   end

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Bench for jtbubl_sndcomm: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against an event-level model of the mailbox.
module tb_jtbubl_sndcomm;
   localparam int NMI_LEN = 4;
   localparam int RST_LEN = 16;
`ifdef JTBUBL_SNDCOMM_STATUS_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic       clk24 = 1'b0;
   logic       rst = 1'b1, cen3 = 1'b0;
   logic       main_cs = 1'b0, main_wrn = 1'b1, main_rdn = 1'b1;
   logic [1:0] main_addr = 2'd0;
   logic [7:0] main_dout = 8'h00, main_din;
   logic       snd_cs = 1'b0, snd_wrn = 1'b1, snd_rdn = 1'b1;
   logic [1:0] snd_addr = 2'd0;
   logic [7:0] snd_dout = 8'h00, snd_din;
   logic       snd_nmi_n, snd_rst;

   always #5 clk24 = ~clk24;

   jtbubl_sndcomm #(.NMI_LEN(NMI_LEN), .RST_LEN(RST_LEN)) dut (
      .clk24(clk24), .rst(rst), .cen3(cen3),
      .main_cs(main_cs), .main_wrn(main_wrn), .main_rdn(main_rdn),
      .main_addr(main_addr), .main_dout(main_dout), .main_din(main_din),
      .snd_cs(snd_cs), .snd_wrn(snd_wrn), .snd_rdn(snd_rdn),
      .snd_addr(snd_addr), .snd_dout(snd_dout), .snd_din(snd_din),
      .snd_nmi_n(snd_nmi_n), .snd_rst(snd_rst)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_cmd, m_rep;
   bit  m_cmd_pend, m_rep_pend, m_ovr, m_nmi_en, m_rst_req, m_nmi_done;
   int  m_stretch, m_nmi_left;
   bit  m_mw_prev, m_mr_prev, m_sw_prev, m_sr_prev;

   function automatic void model_reset();
      m_cmd = 8'h00; m_rep = 8'h00;
      m_cmd_pend = 0; m_rep_pend = 0; m_ovr = 0; m_nmi_en = 0; m_rst_req = 0;
      m_nmi_done = 0; m_nmi_left = 0; m_stretch = RST_LEN;
      m_mw_prev = 0; m_mr_prev = 0; m_sw_prev = 0; m_sr_prev = 0;
   endfunction

   function automatic bit exp_snd_rst();
      return m_rst_req || (m_stretch != 0);
   endfunction

   function automatic logic [7:0] exp_status();
      return STAT ? {5'b0, m_ovr, m_rep_pend, m_cmd_pend} : 8'hff;
   endfunction

   function automatic logic [7:0] exp_main_din();
      if (!(main_cs && !main_rdn)) return 8'hff;
      if (main_addr == 2'd0) return m_rep;
      if (main_addr == 2'd1) return exp_status();
      return 8'hff;
   endfunction

   function automatic logic [7:0] exp_snd_din();
      if (!(snd_cs && !snd_rdn)) return 8'hff;
      if (snd_addr == 2'd0) return m_cmd;
      if (snd_addr == 2'd1) return exp_status();
      return 8'hff;
   endfunction

   // One clock edge of the mailbox, expressed as access events.
   function automatic void model_step();
      bit mw, mr, sw, sr, srst, mw0, mr0, mw3, sr0, sw0, sw1, sw2;
      if (rst) begin
         model_reset();
         return;
      end
      mw = main_cs && !main_wrn;  mr = main_cs && !main_rdn;
      sw = snd_cs && !snd_wrn;    sr = snd_cs && !snd_rdn;
      srst = exp_snd_rst();
      mw0 = mw && !m_mw_prev && main_addr == 2'd0;
      mr0 = mr && !m_mr_prev && main_addr == 2'd0;
      mw3 = mw && !m_mw_prev && main_addr == 2'd3;
      sr0 = sr && !m_sr_prev && snd_addr == 2'd0 && !srst;
      sw0 = sw && !m_sw_prev && snd_addr == 2'd0 && !srst;
      sw1 = sw && !m_sw_prev && snd_addr == 2'd1 && !srst;
      sw2 = sw && !m_sw_prev && snd_addr == 2'd2 && !srst;
      // NMI: a pulse of NMI_LEN ticks, once per pending command.
      if (srst) begin
         m_nmi_left = 0; m_nmi_done = 0;
      end else if (cen3) begin
         if (m_nmi_left > 0) m_nmi_left--;
         else if (!m_nmi_done && m_cmd_pend && m_nmi_en) begin
            m_nmi_left = NMI_LEN; m_nmi_done = 1;
         end else if (m_nmi_done && !m_cmd_pend) m_nmi_done = 0;
      end
      m_ovr = sr0 ? 1'b0 : ((mw0 && m_cmd_pend) ? 1'b1 : m_ovr);
      if (mw0) begin m_cmd = main_dout; m_cmd_pend = 1; end
      else if (sr0) m_cmd_pend = 0;
      if (srst) begin m_rep = 8'h00; m_rep_pend = 0; end
      else if (sw0) begin m_rep = snd_dout; m_rep_pend = 1; end
      else if (mr0) m_rep_pend = 0;
      if (srst) m_nmi_en = 0;
      else if (sw1) m_nmi_en = 1;
      else if (sw2) m_nmi_en = 0;
      if (mw3) m_rst_req = main_dout[0];
      if (mw3 && main_dout[0]) m_stretch = RST_LEN;
      else if (cen3 && m_stretch > 0) m_stretch--;
      m_mw_prev = mw; m_mr_prev = mr; m_sw_prev = sw; m_sr_prev = sr;
   endfunction

   // ---------------- cycle engine ----------------
   int  cyc = 0;
   bit  cen_rand = 0;
   int  rst_ticks = 0, nmi_ticks = 0, nmi_falls = 0;
   bit  prev_nmi = 1;

   task automatic cycle();
      @(negedge clk24);
      cen3 = cen_rand ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
      cyc++;
      #1;
      if (!rst) begin
         check("main_din",  main_din,  exp_main_din());
         check("snd_din",   snd_din,   exp_snd_din());
         check("snd_nmi_n", {7'b0, snd_nmi_n}, {7'b0, m_nmi_left == 0});
         check("snd_rst",   {7'b0, snd_rst},   {7'b0, exp_snd_rst()});
      end
      if (snd_rst && cen3)  rst_ticks++;
      if (!snd_nmi_n && cen3) nmi_ticks++;
      if (prev_nmi && !snd_nmi_n) nmi_falls++;
      prev_nmi = snd_nmi_n;
      @(posedge clk24);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic main_wr(input logic [1:0] a, input logic [7:0] d, input int hold);
      main_cs = 1; main_wrn = 0; main_addr = a; main_dout = d;
      idle(hold);
      main_cs = 0; main_wrn = 1;
      cycle();
   endtask

   task automatic snd_wr(input logic [1:0] a, input logic [7:0] d);
      snd_cs = 1; snd_wrn = 0; snd_addr = a; snd_dout = d;
      idle(2);
      snd_cs = 0; snd_wrn = 1;
      cycle();
   endtask

   // Read with a literal expectation taken while the strobe is low.
   task automatic snd_rd(input string name, input logic [1:0] a, input logic [7:0] exp);
      snd_cs = 1; snd_rdn = 0; snd_addr = a;
      #1 check(name, snd_din, exp);
      idle(2);
      snd_cs = 0; snd_rdn = 1;
      cycle();
   endtask

   task automatic main_rd(input string name, input logic [1:0] a, input logic [7:0] exp);
      main_cs = 1; main_rdn = 0; main_addr = a;
      #1 check(name, main_din, exp);
      idle(2);
      main_cs = 0; main_rdn = 1;
      cycle();
   endtask

   task automatic wait_snd_rst_low();
      for (int i = 0; i < 300 && snd_rst; i++) cycle();
      check("snd_rst_release_timeout", {7'b0, snd_rst}, 8'h00);
   endtask

   function automatic logic [7:0] st(input logic [7:0] v);
      return STAT ? v : 8'hff;
   endfunction

   // ---------------- random traffic ----------------
   int mh = 0, sh = 0;

   task automatic random_cycle();
      int r;
      if ($urandom_range(0, 599) == 0) begin
         rst = 1; mh = 0; sh = 0;
         main_cs = 0; main_wrn = 1; main_rdn = 1;
         snd_cs = 0; snd_wrn = 1; snd_rdn = 1;
         cycle();
         rst = 0;
         return;
      end
      if (mh > 0) begin
         mh--;
         if (mh == 0) begin main_cs = 0; main_wrn = 1; main_rdn = 1; end
      end else if ($urandom_range(0, 3) == 0) begin
         r = $urandom_range(0, 31);
         main_cs = 1; main_dout = 8'($urandom);
         if (r < 12)      begin main_wrn = 0; main_addr = 2'd0; end
         else if (r < 20) begin main_rdn = 0; main_addr = 2'd0; end
         else if (r < 25) begin main_rdn = 0; main_addr = 2'd1; end
         else if (r == 25) begin main_wrn = 0; main_addr = 2'd3; end
         else if (r < 28) begin main_wrn = 0; main_addr = 2'($urandom_range(1, 2)); end
         else             begin main_rdn = 0; main_addr = 2'($urandom_range(2, 3)); end
         mh = $urandom_range(1, 4);
      end
      if (sh > 0) begin
         sh--;
         if (sh == 0) begin snd_cs = 0; snd_wrn = 1; snd_rdn = 1; end
      end else if ($urandom_range(0, 3) == 0) begin
         r = $urandom_range(0, 31);
         snd_cs = 1; snd_dout = 8'($urandom);
         if (r < 10)      begin snd_rdn = 0; snd_addr = 2'd0; end
         else if (r < 17) begin snd_wrn = 0; snd_addr = 2'd0; end
         else if (r < 22) begin snd_wrn = 0; snd_addr = 2'd1; end
         else if (r < 24) begin snd_wrn = 0; snd_addr = 2'd2; end
         else if (r < 29) begin snd_rdn = 0; snd_addr = 2'd1; end
         else             begin snd_rdn = 0; snd_addr = 2'($urandom_range(2, 3)); end
         sh = $urandom_range(1, 4);
      end
      cycle();
   endtask

   int t0, f0, r0;

   initial begin
      model_reset();
      rst = 1;
      idle(3);
      rst = 0;
      #1;
      check("reset_main_din",  main_din, 8'hff);
      check("reset_snd_din",   snd_din,  8'hff);
      check("reset_snd_nmi_n", {7'b0, snd_nmi_n}, 8'h01);
      check("reset_snd_rst",   {7'b0, snd_rst},   8'h01);
      r0 = rst_ticks;
      wait_snd_rst_low();
      check("reset_stretch_ticks", 8'(rst_ticks - r0), 8'd16);

      // Single command, long strobe, one NMI pulse.
      snd_wr(2'd1, 8'h00);
      t0 = nmi_ticks; f0 = nmi_falls;
      main_wr(2'd0, 8'h5a, 6);
      idle(40);
      check("nmi_pulse_ticks", 8'(nmi_ticks - t0), 8'd4);
      check("nmi_pulse_count", 8'(nmi_falls - f0), 8'd1);
      snd_rd("snd_cmd_5a", 2'd0, 8'h5a);
      idle(2);
      snd_rd("status_after_read", 2'd1, st(8'h00));

      // Overrun: two commands, one NMI.
      idle(8);
      f0 = nmi_falls;
      main_wr(2'd0, 8'h11, 2);
      idle(2);
      main_wr(2'd0, 8'h22, 2);
      idle(20);
      snd_rd("status_overrun", 2'd1, st(8'h05));
      snd_rd("snd_cmd_22", 2'd0, 8'h22);
      idle(10);
      snd_rd("status_cleared", 2'd1, st(8'h00));
      check("overrun_single_nmi", 8'(nmi_falls - f0), 8'd1);

      // Reply path.
      snd_wr(2'd0, 8'hc3);
      main_rd("main_status_rep", 2'd1, st(8'h02));
      main_rd("main_reply_c3", 2'd0, 8'hc3);
      main_rd("main_status_rep_clr", 2'd1, st(8'h00));

      // Sound reset request and its stretch; nmi_en is cleared by it.
      r0 = rst_ticks;
      main_wr(2'd3, 8'h01, 1);
      main_wr(2'd3, 8'h00, 1);
      wait_snd_rst_low();
      check("req_stretch_ticks", 8'(rst_ticks - r0), 8'd16);
      f0 = nmi_falls;
      main_wr(2'd0, 8'h77, 1);
      idle(30);
      check("no_nmi_after_rst", 8'(nmi_falls - f0), 8'd0);

      // Same-clock command write and command read: write wins, overrun cleared.
      main_wr(2'd0, 8'h88, 1);
      snd_rd("status_pre_race", 2'd1, st(8'h05));
      main_cs = 1; main_wrn = 0; main_addr = 2'd0; main_dout = 8'h9c;
      snd_cs = 1; snd_rdn = 0; snd_addr = 2'd0;
      cycle();
      main_cs = 0; main_wrn = 1; snd_cs = 0; snd_rdn = 1;
      cycle();
      snd_rd("status_race", 2'd1, st(8'h01));
      snd_rd("snd_cmd_race", 2'd0, 8'h9c);

      // rst mid-pulse returns everything to reset values.
      snd_wr(2'd1, 8'h00);
      main_wr(2'd0, 8'hab, 1);
      for (int i = 0; i < 40 && snd_nmi_n; i++) cycle();
      check("nmi_before_rst", {7'b0, snd_nmi_n}, 8'h00);
      rst = 1;
      cycle();
      rst = 0;
      check("nmi_after_rst", {7'b0, snd_nmi_n}, 8'h01);
      check("snd_rst_after_rst", {7'b0, snd_rst}, 8'h01);
      wait_snd_rst_low();

      // Random traffic.
      cen_rand = 1;
      for (int i = 0; i < 4000; i++) random_cycle();
      main_cs = 0; main_wrn = 1; main_rdn = 1;
      snd_cs = 0; snd_wrn = 1; snd_rdn = 1;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/jtbubl_sndcomm.md
# jtbubl_sndcomm

Bidirectional command/reply mailbox between the main Z80 and the sound Z80. It holds the main-to-sound command latch and the sound-to-main reply latch with pending flags. It generates the sound CPU NMI through a small state machine and drives the sound CPU reset line with a guaranteed minimum width. The main CPU address decoder feeds it the sound chip-select; it drives the sound CPU's NMI, reset and data-in mux.

## Interface
Parameters:
- NMI_LEN, 4: length of the snd_nmi_n low pulse, in cen3 ticks (1..255).
- RST_LEN, 16: minimum snd_rst high width, in cen3 ticks (1..255).

Ports:
- clk24  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cen3  in  1  sound CPU clock enable; times the NMI pulse and the reset stretch.
- main_cs  in  1  main CPU sound-region select (decoded, includes mreq).
- main_wrn / main_rdn  in  1  main CPU strobes, active low.
- main_addr  in  2  register select.
- main_dout  in  8  main CPU write data.
- main_din  out  8  read data to main CPU.
- snd_cs  in  1  sound CPU mailbox-region select.
- snd_wrn / snd_rdn  in  1  sound CPU strobes, active low.
- snd_addr  in  2  register select.
- snd_dout  in  8  sound CPU write data.
- snd_din  out  8  read data to sound CPU.
- snd_nmi_n  out  1  sound CPU NMI, active low.
- snd_rst  out  1  sound CPU reset, active high.

## Operation
- Each write or read access acts once, on the rising edge of (cs & !strobe), detected with a registered copy. A strobe held across many clocks is one access.
- Main map (main_addr):
  - 0 write: cmd latch, sets cmd_pend. If cmd_pend was already set, also sets overrun.
  - 0 read: reply latch. The read edge clears rep_pend.
  - 1 read: status {5'b0, overrun, rep_pend, cmd_pend}.
  - 3 write: bit0 sets rst_req.
  - Any other access: reads 8'hff, writes are ignored.
- Sound map (snd_addr):
  - 0 read: cmd latch. The read edge clears cmd_pend and overrun.
  - 0 write: reply latch, sets rep_pend.
  - 1 write: nmi_en=1.
  - 2 write: nmi_en=0.
  - 1 read: same status byte as main address 1.
  - Other reads: 8'hff.
- main_din and snd_din are combinational from the registers. Latch contents never change on a read.
- NMI state machine, advancing only on cen3:
  - IDLE: go to PULSE when cmd_pend & nmi_en. Load the counter with NMI_LEN-1.
  - PULSE: snd_nmi_n=0. Decrement the counter; at 0 go to WAIT. The pulse always completes, even if nmi_en is cleared mid-pulse.
  - WAIT: snd_nmi_n=1. Return to IDLE when cmd_pend==0. A rewrite while pending does not retrigger the NMI.
- Sound reset:
  - snd_rst = rst_req | (stretch!=0).
  - A main write to 3 with bit0=1 loads stretch with RST_LEN. The counter decrements on cen3.
  - A write with bit0=0 clears rst_req. snd_rst falls only once stretch also reaches 0.
- While snd_rst=1, the sound-side state is held at its reset value: nmi_en=0, FSM=IDLE, rep_pend=0. The reply latch is held at 8'h00. The cmd latch and cmd_pend are kept.

## Timing
- Reset values:
  - main_din=snd_din=8'hff.
  - cmd latch = reply latch = 8'h00; cmd_pend=rep_pend=overrun=0.
  - nmi_en=0, FSM=IDLE, snd_nmi_n=1.
  - rst_req=0; stretch=RST_LEN, so snd_rst=1 for RST_LEN cen3 ticks after rst.
- Write edge at clock N: the latch and flag are visible at N+1 on both din buses.
- NMI: cmd_pend rises at N+1. snd_nmi_n falls on the first cen3 at or after N+1 when nmi_en=1. It stays low for exactly NMI_LEN cen3 ticks.
- Same-clock main write at 0 and sound read at 0: the write wins. The latch takes the new value, cmd_pend stays 1, and overrun is cleared.
- Same-clock sound reply write and main reply read: the write wins and rep_pend stays 1.
- A new reset request during an active stretch reloads stretch to RST_LEN.
- rst asserted mid-pulse: the next clock returns everything to its reset values.

## Configuration
- JTBUBL_SNDCOMM_STATUS_EN defined: the status register is readable at address 1 on both sides and the overrun flag is implemented.
- Not defined: address 1 reads return 8'hff and the overrun logic is absent. All other behaviour is identical.

## Test plan
- After rst with RST_LEN=16: snd_rst=1 for 16 cen3 ticks then 0; snd_nmi_n=1; both din buses 8'hff.
- Sound writes 1 (nmi_en), then main writes 8'h5A at 0, strobe held for 6 clocks: one 4-tick NMI pulse. Sound reads 0 and gets 8'h5A; status reads 8'h00 afterwards.
- Main writes 8'h11 then 8'h22 at 0 with no sound read: status reads 8'h05 and exactly one NMI occurs. The sound read returns 8'h22; status then reads 8'h00.
- Sound writes 8'hC3 at 0: main status bit1=1. Main read at 0 returns 8'hC3; bit1 then 0.
- Main writes 3 with 8'h01 then 8'h00 after 2 clocks: snd_rst is high for 16 cen3 ticks. nmi_en is cleared: a subsequent command produces no NMI.
- Write and read at address 0 in the same clock: the latch holds the new value and cmd_pend=1.
